run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
Sequences one program execution on the single-cycle core in response to a host req/ack handshake. It holds the program counter at its start address via `start`, then enables the core. It watches `pc` against a programmable done address and returns `ack`. A cycle counter and a watchdog timeout support performance measurement and detect hung programs.

Parameters:
PC_BITS, 10, width of program counter and done address
CYCLE_BITS, 16, width of the run-cycle counter
START_CYCLES, 2, cycles `start` is held high before the run begins (must be >= 1)
TIMEOUT_CYCLES, 16'hFFFF, RUN cycles allowed before watchdog abort (must be >= 1, < 2^CYCLE_BITS)

Ports:
clock  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
req  input  1  host run request, level (4-phase handshake)
done_addr  input  PC_BITS  PC value marking program completion; sampled every RUN cycle
pc  input  PC_BITS  current program counter from the core
start  output  1  to program counter: hold PC at start address
run_en  output  1  core enable; external logic gates regWrite/memWrite with it
busy  output  1  high in START or RUN
ack  output  1  run finished (normal or timeout)
timeout  output  1  run ended by watchdog
cycle_count  output  CYCLE_BITS  number of RUN cycles in current/last run

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; start, run_en, busy, ack, timeout = 0; cycle_count = 0.
  - Internal req_q = 1, so a req held high through reset must drop and rise again to start a run.
- All outputs are registered or decoded from the state register only (Moore); there is no combinational path from req/pc to outputs.
- req rising edge = (req == 1 && req_q == 0) at a clock edge; req_q <= req every edge.
- States:
  - IDLE: all outputs 0; cycle_count holds its last value.
    - On a req rising edge -> START; cycle_count <= 0; internal start counter <= 0.
  - START: start = 1, busy = 1, run_en = 0; lasts exactly START_CYCLES cycles, then -> RUN.
    - If req == 0 at any edge -> IDLE (abort, no ack).
  - RUN: run_en = 1, busy = 1.
    - Every edge in RUN: cycle_count <= cycle_count + 1, including the exit edge.
    - Exit priority at each edge: req == 0 -> IDLE (abort); else pc == done_addr -> DONE; else cycle_count == TIMEOUT_CYCLES-1 -> TMO.
    - Done takes priority over timeout when both hold on the same edge.
  - DONE: ack = 1, run_en = 0, busy = 0; cycle_count frozen. When req == 0 at an edge -> IDLE; ack falls in the following cycle.
  - TMO: ack = 1, timeout = 1, otherwise as DONE; leaves on req == 0.
- A req rising edge outside IDLE is ignored. Only one run per req pulse; a new run needs req low then high again.
- Latency: req rises before edge k -> start high from edge k to edge k+START_CYCLES -> run_en high from edge k+START_CYCLES.
- Boundary: if pc == done_addr on the first RUN cycle, DONE is entered with cycle_count = 1.
- Boundary: cycle_count never wraps in RUN; its maximum is TIMEOUT_CYCLES.
- Reset mid-run returns to IDLE immediately with all outputs 0.
- done_addr changes are honoured on the next RUN-cycle compare; no latching.

Test Plan:
- Reset with req = 1 held, release reset_n -> stays IDLE, start = 0; drop and raise req -> start = 1 for exactly 2 cycles, then run_en = 1.
- done_addr = 565; a pc model increments from 0 each RUN cycle -> ack = 1, timeout = 0, cycle_count = 566; after req drops, ack = 0 one cycle later, state IDLE.
- TIMEOUT_CYCLES = 10, pc never equals done_addr -> after 10 RUN cycles ack = 1, timeout = 1, cycle_count = 10, run_en = 0.
- TIMEOUT_CYCLES = 10, pc reaches done_addr on the 10th RUN cycle -> DONE wins: ack = 1, timeout = 0, cycle_count = 10.
- req dropped during START, and separately on RUN cycle 5 -> return to IDLE, no ack; cycle_count = 5 in the RUN case; a fresh req rise starts a run with the count cleared.
- reset_n pulsed low asynchronously on RUN cycle 3 -> all outputs 0 without waiting for a clock edge; cycle_count = 0.

Source files
------------

// File: rtl/run_controller.sv
// Run sequencer for the single-cycle core: req/ack host handshake, start hold,
// done-address detection, RUN-cycle counter and watchdog abort.
module run_controller #(
  parameter int unsigned PC_BITS        = 10,
  parameter int unsigned CYCLE_BITS     = 16,
  parameter int unsigned START_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic [PC_BITS-1:0]    done_addr,
  input  logic [PC_BITS-1:0]    pc,
  output logic                  start,
  output logic                  run_en,
  output logic                  busy,
  output logic                  ack,
  output logic                  timeout,
  output logic [CYCLE_BITS-1:0] cycle_count
);

  localparam int unsigned SC_BITS = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SC_BITS-1:0]    SC_LAST  = SC_BITS'(START_CYCLES - 1);
  localparam logic [CYCLE_BITS-1:0] TMO_LAST = CYCLE_BITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    TMO   = 3'd4
  } state_t;

  state_t             state;
  logic               req_q;
  logic [SC_BITS-1:0] start_cnt;

  // req_q resets high so a req held through reset cannot launch a run.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_q       <= 1'b1;
      start_cnt   <= '0;
      start       <= 1'b0;
      run_en      <= 1'b0;
      busy        <= 1'b0;
      ack         <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      req_q <= req;
      case (state)
        IDLE: begin
          if (req && !req_q) begin
            state       <= START;
            cycle_count <= '0;
            start_cnt   <= '0;
            start       <= 1'b1;
            busy        <= 1'b1;
          end
        end

        START: begin
          if (!req) begin
            state <= IDLE;
            start <= 1'b0;
            busy  <= 1'b0;
          end else if (start_cnt == SC_LAST) begin
            state  <= RUN;
            start  <= 1'b0;
            run_en <= 1'b1;
          end else begin
            start_cnt <= start_cnt + SC_BITS'(1);
          end
        end

        // Counter advances on every RUN edge, exit edge included; done beats timeout.
        RUN: begin
          cycle_count <= cycle_count + CYCLE_BITS'(1);
          if (!req) begin
            state  <= IDLE;
            run_en <= 1'b0;
            busy   <= 1'b0;
          end else if (pc == done_addr) begin
            state  <= DONE;
            run_en <= 1'b0;
            busy   <= 1'b0;
            ack    <= 1'b1;
          end else if (cycle_count == TMO_LAST) begin
            state   <= TMO;
            run_en  <= 1'b0;
            busy    <= 1'b0;
            ack     <= 1'b1;
            timeout <= 1'b1;
          end
        end

        DONE, TMO: begin
          if (!req) begin
            state   <= IDLE;
            ack     <= 1'b0;
            timeout <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          start   <= 1'b0;
          run_en  <= 1'b0;
          busy    <= 1'b0;
          ack     <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: a long-timeout instance (a) and a
// TIMEOUT_CYCLES=10 instance (b); each run end is checked against a queued record.
module tb_run_controller;

  localparam int unsigned PC_BITS    = 10;
  localparam int unsigned CYCLE_BITS = 16;

  typedef struct {
    logic                  ack;
    logic                  tmo;
    logic [CYCLE_BITS-1:0] cnt;
  } exp_t;

  logic clock, reset_n;

  logic                  req_a, start_a, run_en_a, busy_a, ack_a, timeout_a;
  logic [PC_BITS-1:0]    done_a, pc_a;
  logic [CYCLE_BITS-1:0] cycle_count_a;

  logic                  req_b, start_b, run_en_b, busy_b, ack_b, timeout_b;
  logic [PC_BITS-1:0]    done_b, pc_b;
  logic [CYCLE_BITS-1:0] cycle_count_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  exp_t qa[$];
  exp_t qb[$];

  run_controller #(
    .PC_BITS(PC_BITS), .CYCLE_BITS(CYCLE_BITS),
    .START_CYCLES(2), .TIMEOUT_CYCLES(16'hFFFF)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .req(req_a), .done_addr(done_a), .pc(pc_a),
    .start(start_a), .run_en(run_en_a), .busy(busy_a), .ack(ack_a),
    .timeout(timeout_a), .cycle_count(cycle_count_a)
  );

  run_controller #(
    .PC_BITS(PC_BITS), .CYCLE_BITS(CYCLE_BITS),
    .START_CYCLES(2), .TIMEOUT_CYCLES(10)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .req(req_b), .done_addr(done_b), .pc(pc_b),
    .start(start_b), .run_en(run_en_b), .busy(busy_b), .ack(ack_b),
    .timeout(timeout_b), .cycle_count(cycle_count_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic a, input logic t, input int c);
    exp_t e;
    e.ack = a;
    e.tmo = t;
    e.cnt = CYCLE_BITS'(c);
    return e;
  endfunction

  // Monitors: a busy fall marks the end of a run (normal, timeout or abort).
  logic prev_busy_a = 1'b0;
  logic prev_busy_b = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (prev_busy_a && !busy_a) begin
      if (qa.size() == 0) begin
        total_cnt++;
        $display("FAIL a_unexpected_end: run ended with no queued record (t=%0t)", $time);
      end else begin
        e = qa.pop_front();
        check("a_end_ack", 32'(ack_a), 32'(e.ack));
        check("a_end_timeout", 32'(timeout_a), 32'(e.tmo));
        check("a_end_cycle_count", 32'(cycle_count_a), 32'(e.cnt));
      end
    end
    prev_busy_a = busy_a;
  end

  always @(negedge clock) begin
    exp_t e;
    if (prev_busy_b && !busy_b) begin
      if (qb.size() == 0) begin
        total_cnt++;
        $display("FAIL b_unexpected_end: run ended with no queued record (t=%0t)", $time);
      end else begin
        e = qb.pop_front();
        check("b_end_ack", 32'(ack_b), 32'(e.ack));
        check("b_end_timeout", 32'(timeout_b), 32'(e.tmo));
        check("b_end_cycle_count", 32'(cycle_count_b), 32'(e.cnt));
      end
    end
    prev_busy_b = busy_b;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_run(input bit sel);
    int n = 0;
    while (!(sel ? run_en_b : run_en_a) && n < 50) begin
      tick();
      n++;
    end
    check(sel ? "b_wait_run_en" : "a_wait_run_en", 32'(sel ? run_en_b : run_en_a), 32'd1);
  endtask

  // pc model: 0 on the first RUN cycle, +1 after every RUN edge.
  task automatic pc_run(input bit sel, input int limit);
    int n = 0;
    while ((sel ? busy_b : busy_a) && n < limit) begin
      tick();
      if (sel ? busy_b : busy_a) begin
        if (sel) pc_b = pc_b + PC_BITS'(1);
        else     pc_a = pc_a + PC_BITS'(1);
      end
      n++;
    end
    check(sel ? "b_run_ended" : "a_run_ended", 32'(sel ? busy_b : busy_a), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n = 1'b0;
    req_a = 1'b1; done_a = '0; pc_a = '0;
    req_b = 1'b0; done_b = '0; pc_b = '0;

    // Reset state with req held high
    #2;
    check("rst_start", 32'(start_a), 32'd0);
    check("rst_run_en", 32'(run_en_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_ack", 32'(ack_a), 32'd0);
    check("rst_timeout", 32'(timeout_a), 32'd0);
    check("rst_cycle_count", 32'(cycle_count_a), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) tick();
    check("held_req_no_start", 32'(start_a), 32'd0);
    check("held_req_no_busy", 32'(busy_a), 32'd0);

    // Fresh rise: start for exactly two cycles, then run_en; done at pc 565
    done_a = PC_BITS'(565);
    pc_a   = '0;
    req_a  = 1'b0;
    tick();
    req_a = 1'b1;
    qa.push_back(mk(1'b1, 1'b0, 566));
    tick();
    check("lat_start_c1", 32'(start_a), 32'd1);
    check("lat_run_en_c1", 32'(run_en_a), 32'd0);
    check("lat_busy_c1", 32'(busy_a), 32'd1);
    tick();
    check("lat_start_c2", 32'(start_a), 32'd1);
    check("lat_run_en_c2", 32'(run_en_a), 32'd0);
    tick();
    check("lat_start_c3", 32'(start_a), 32'd0);
    check("lat_run_en_c3", 32'(run_en_a), 32'd1);
    pc_run(1'b0, 1000);
    check("a_done_run_en", 32'(run_en_a), 32'd0);
    req_a = 1'b0;
    check("a_ack_before_drop_edge", 32'(ack_a), 32'd1);
    tick();
    check("a_ack_after_drop", 32'(ack_a), 32'd0);
    check("a_idle_busy", 32'(busy_a), 32'd0);
    check("a_idle_count_hold", 32'(cycle_count_a), 32'd566);

    // Watchdog: pc never matches, TIMEOUT_CYCLES=10
    done_b = PC_BITS'(1023);
    pc_b   = '0;
    qb.push_back(mk(1'b1, 1'b1, 10));
    req_b = 1'b1;
    wait_run(1'b1);
    pc_run(1'b1, 100);
    check("b_tmo_run_en", 32'(run_en_b), 32'd0);
    req_b = 1'b0;
    repeat (2) tick();
    check("b_tmo_cleared", 32'(timeout_b), 32'd0);

    // Done and timeout on the same edge: done wins
    done_b = PC_BITS'(9);
    pc_b   = '0;
    qb.push_back(mk(1'b1, 1'b0, 10));
    req_b = 1'b1;
    wait_run(1'b1);
    pc_run(1'b1, 100);
    req_b = 1'b0;
    repeat (2) tick();

    // Abort during START: count cleared on entry, no ack
    done_b = PC_BITS'(1023);
    qb.push_back(mk(1'b0, 1'b0, 0));
    req_b = 1'b1;
    tick();
    check("b_start_abort_in_start", 32'(start_b), 32'd1);
    req_b = 1'b0;
    tick();
    check("b_start_abort_idle", 32'(busy_b), 32'd0);
    check("b_start_abort_start", 32'(start_b), 32'd0);
    tick();

    // Abort on RUN cycle 5
    pc_b = '0;
    qb.push_back(mk(1'b0, 1'b0, 5));
    req_b = 1'b1;
    wait_run(1'b1);
    repeat (4) tick();
    req_b = 1'b0;
    tick();
    check("b_run_abort_count", 32'(cycle_count_b), 32'd5);
    check("b_run_abort_ack", 32'(ack_b), 32'd0);
    tick();

    // Fresh run after abort clears the count
    done_b = PC_BITS'(2);
    pc_b   = '0;
    qb.push_back(mk(1'b1, 1'b0, 3));
    req_b = 1'b1;
    tick();
    check("b_fresh_count_cleared", 32'(cycle_count_b), 32'd0);
    check("b_fresh_start", 32'(start_b), 32'd1);
    wait_run(1'b1);
    pc_run(1'b1, 100);
    req_b = 1'b0;
    repeat (2) tick();

    // Asynchronous reset on RUN cycle 3
    done_a = PC_BITS'(1023);
    pc_a   = '0;
    qa.push_back(mk(1'b0, 1'b0, 0));
    req_a = 1'b1;
    wait_run(1'b0);
    repeat (3) tick();
    check("a_pre_reset_count", 32'(cycle_count_a), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_start", 32'(start_a), 32'd0);
    check("arst_run_en", 32'(run_en_a), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_ack", 32'(ack_a), 32'd0);
    check("arst_timeout", 32'(timeout_a), 32'd0);
    check("arst_cycle_count", 32'(cycle_count_a), 32'd0);
    req_a = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) tick();

    check("a_queue_drained", 32'(qa.size()), 32'd0);
    check("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
